// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_LANES       = 4;
  localparam int BYTE_WIDTH       = 8;
  localparam int MAX_READ_LATENCY = 15;
  localparam int CNT_WIDTH        = $clog2(MAX_READ_LATENCY + 1);

endpackage

// File: rtl/dmem_storage.sv
// Word-addressed storage: byte-lane write port, one registered read port.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             i_clr,
  input  logic                             i_we,
  input  logic [BYTE_LANES-1:0]            i_be,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [BYTE_LANES*BYTE_WIDTH-1:0] i_wdata,
  input  logic                             i_re,
  input  logic [ADDR_WIDTH-1:0]            i_raddr,
  output logic [BYTE_LANES*BYTE_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [BYTE_LANES*BYTE_WIDTH-1:0] r_mem [DEPTH];
  logic [BYTE_LANES*BYTE_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTE_LANES; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][b*BYTE_WIDTH +: BYTE_WIDTH]
          <= i_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Array has no reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latency-timed loads, byte-masked stores.
// Optional sticky error flags built when DMEM_ERR_CHECK_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [BYTE_LANES-1:0] mem_write_set,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  err_misaligned,
  output logic                  err_conflict
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT =
    (READ_LATENCY > 1) ? CNT_WIDTH'(READ_LATENCY - 2) : '0;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]  r_idx;
  logic [ADDR_WIDTH-1:0]  w_idx;
  logic [ADDR_WIDTH-1:0]  w_raddr;
  logic                   w_idle;
  logic                   w_load;
  logic                   w_store;
  logic                   w_re;
  logic                   r_valid;
  logic                   w_unused;

  assign w_idx    = address[ADDR_WIDTH+1:2];
  assign w_idle   = (r_state == IDLE);
  assign w_load   = w_idle & mem_read & ~mem_write;
  assign w_unused = &{1'b0, address[31:ADDR_WIDTH+2],
                      address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_next = (READ_LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latency 1 reads straight from the request address.
  always_comb begin
    busy    = (r_state == WAIT) | w_load;
    w_store = w_idle & mem_write & ~rst;
    w_re    = ~rst & (w_next == DONE);
    w_raddr = w_idle ? w_idx : r_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_load) begin
      r_cnt <= CNT_INIT;
      r_idx <= w_idx;
    end else if (r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_next == DONE);
    end
  end

  assign read_valid = r_valid;

  dmem_storage #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk     (clk),
    .i_clr   (rst),
    .i_we    (w_store),
    .i_be    (mem_write_set),
    .i_waddr (w_idx),
    .i_wdata (write_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (read_data)
  );

`ifdef DMEM_ERR_CHECK_EN
  logic r_err_mis;
  logic r_err_conf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_mis  <= 1'b0;
      r_err_conf <= 1'b0;
    end else if (w_idle) begin
      if ((mem_read | mem_write) && address[1:0] != 2'b00) begin
        r_err_mis <= 1'b1;
      end
      if (mem_read && mem_write) begin
        r_err_conf <= 1'b1;
      end
    end
  end

  assign err_misaligned = r_err_mis;
  assign err_conflict   = r_err_conf;
`else
  assign err_misaligned = 1'b0;
  assign err_conflict   = 1'b0;
`endif

endmodule
